sm83_alu_flags: RTL
===================

Name: sm83_alu_flags

Overview:
- Flag register file and primary carry buffer for the SM83 ALU; holds Z, N, H and C.
- Sits directly upstream of the ALU control stage and feeds it zero, carry, pri_carry, daa_carry and daa_neg.
- Consumes the ALU result status and the control stage's shift_out / daa_carry_out to update flags.
- Provides the F byte for PUSH AF, loads F for POP AF, and selects the ALU carry-in.

Parameters:
- none (widths fixed by the SM83 architecture)

Ports:
- clk  in  1  core clock; all state updates on posedge
- nreset  in  1  asynchronous active-low reset
- alu_zero  in  1  ALU 8-bit result is zero
- alu_half  in  1  ALU carry/borrow out of bit 3
- alu_carry  in  1  ALU carry/borrow out of bit 7
- shift_out  in  1  shift carry from ALU control
- daa_carry_out  in  1  DAA carry from ALU control
- z_we, n_we, h_we, c_we  in  1 each  per-flag write enables
- z_sel  in  1  0 = alu_zero, 1 = constant 0
- n_val  in  1  value written to N
- h_sel  in  2  0 = alu_half, 1 = const 0, 2 = const 1, 3 = reserved
- c_sel  in  3  0 = alu_carry, 1 = shift_out, 2 = daa_carry_out, 3 = const 0, 4 = const 1, 5 = !C (CCF), 6/7 = reserved
- f_load  in  1  load flags from dbus[7:4] (POP AF)
- dbus  in  8  data bus
- pri_we  in  1  capture alu_carry into primary carry buffer
- pri_clr  in  1  clear primary carry buffer
- cin_sel  in  2  ALU carry-in: 0 = 0, 1 = 1, 2 = C flag, 3 = pri_carry
- f_out  out  8  {Z,N,H,C,4'b0000}
- zero, carry  out  1  Z and C flags
- daa_carry, daa_neg  out  1  H and N flags
- pri_carry  out  1  primary carry buffer
- alu_cin  out  1  combinational ALU carry-in

Behaviour:
- Reset (async, nreset low): Z = N = H = C = 0 and pri_carry = 0, so f_out = 0x00. All outputs are valid from reset assertion. Reset mid-operation discards any pending write.
- Flag writes are registered: the new value is visible on the cycle after the posedge. Same-cycle reads see the old value; alu_cin with cin_sel = 2 uses the pre-update C.
- Per-flag updates are independent; any subset of *_we may be active together.
- c_sel = 5 complements the current C (CCF). Reserved selects hold the flag and fire an assertion.
- f_load priority: when f_load = 1, {Z,N,H,C} <= dbus[7:4] and all *_we are ignored that cycle. f_load together with any *_we fires an assertion.
- dbus[3:0] is ignored; f_out[3:0] is always 0.
- Primary carry buffer: pri_clr has priority over pri_we; pri_we alone latches alu_carry. Otherwise pri_carry holds. It is independent of C, so 16-bit ops (ADD HL, ADD SP,e, INC/DEC rr) chain low to high byte without touching flags.
- alu_cin is purely combinational from cin_sel and the registered C / pri_carry. There is no path from the ALU inputs to alu_cin, so no combinational loop.
- X on a write enable or select fires an assertion; the flag holds in synthesis.

Decomposition:
- sm83_pkg holds enums h_sel_t, c_sel_t, cin_sel_t, plus the flag bit positions FLAG_Z = 7, FLAG_N = 6, FLAG_H = 5, FLAG_C = 4.
- No sub-module: one flat always_ff for flags and buffer, one always_comb for alu_cin.

Test Plan:
- Reset: pulse nreset low mid-cycle -> f_out = 0x00, pri_carry = 0 immediately, without waiting for a clock edge.
- ADD: alu_zero = 1, alu_half = 1, alu_carry = 1; all we = 1, z_sel = 0, n_val = 0, h_sel = 0, c_sel = 0 -> f_out = 0xB0 next cycle and 0xB0 still while we = 0.
- POP AF: f_load = 1, dbus = 0x5F, c_we = 1 same cycle -> f_out = 0x50; assertion fires; c_sel is ignored.
- CCF twice: C = 1, c_we = 1, c_sel = 5, h_we = 1, h_sel = 1, n_we = 1, n_val = 0 -> C = 0, H = 0, N = 0; repeat -> C = 1.
- 16-bit chain: pri_we = 1, alu_carry = 1, then cin_sel = 3 -> alu_cin = 1 while C stays 0. Next cycle pri_we = 1 with pri_clr = 1 -> pri_carry = 0.
- Rotate and DAA: c_sel = 1, shift_out = 1 -> C = 1; then c_sel = 2, daa_carry_out = 0 with z_we = 1, alu_zero = 1 -> f_out = 0x80.

Source files
------------

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared encodings for the SM83 ALU flag register.
//   h_sel_t   - H flag source select
//   c_sel_t   - C flag source select (includes CCF complement)
//   cin_sel_t - ALU carry-in source select
//   FLAG_*    - bit positions of Z/N/H/C inside the F byte
package sm83_pkg;

  typedef enum logic [1:0] {
    H_ALU  = 2'd0,
    H_ZERO = 2'd1,
    H_ONE  = 2'd2,
    H_RSVD = 2'd3
  } h_sel_t;

  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_SHIFT = 3'd1,
    C_DAA   = 3'd2,
    C_ZERO  = 3'd3,
    C_ONE   = 3'd4,
    C_CPL   = 3'd5,
    C_RSVD6 = 3'd6,
    C_RSVD7 = 3'd7
  } c_sel_t;

  typedef enum logic [1:0] {
    CIN_ZERO = 2'd0,
    CIN_ONE  = 2'd1,
    CIN_FLAG = 2'd2,
    CIN_PRI  = 2'd3
  } cin_sel_t;

  localparam int unsigned FLAG_Z = 7;
  localparam int unsigned FLAG_N = 6;
  localparam int unsigned FLAG_H = 5;
  localparam int unsigned FLAG_C = 4;

endpackage

// File: rtl/sm83_alu_flags_if.sv
// sm83_alu_flags_if: bundle of the status/control signals exchanged between
// the ALU control stage (master) and the flag register (slave).
//   master drives ALU status, write enables, selects, dbus, carry-buffer
//   controls and cin_sel; it receives F, the flag taps and alu_cin.
interface sm83_alu_flags_if;
  logic       alu_zero;
  logic       alu_half;
  logic       alu_carry;
  logic       shift_out;
  logic       daa_carry_out;
  logic       z_we;
  logic       n_we;
  logic       h_we;
  logic       c_we;
  logic       z_sel;
  logic       n_val;
  logic [1:0] h_sel;
  logic [2:0] c_sel;
  logic       f_load;
  logic [7:0] dbus;
  logic       pri_we;
  logic       pri_clr;
  logic [1:0] cin_sel;
  logic [7:0] f_out;
  logic       zero;
  logic       carry;
  logic       daa_carry;
  logic       daa_neg;
  logic       pri_carry;
  logic       alu_cin;

  modport master (
    output alu_zero, alu_half, alu_carry, shift_out, daa_carry_out,
           z_we, n_we, h_we, c_we, z_sel, n_val, h_sel, c_sel,
           f_load, dbus, pri_we, pri_clr, cin_sel,
    input  f_out, zero, carry, daa_carry, daa_neg, pri_carry, alu_cin
  );

  modport slave (
    input  alu_zero, alu_half, alu_carry, shift_out, daa_carry_out,
           z_we, n_we, h_we, c_we, z_sel, n_val, h_sel, c_sel,
           f_load, dbus, pri_we, pri_clr, cin_sel,
    output f_out, zero, carry, daa_carry, daa_neg, pri_carry, alu_cin
  );
endinterface

// File: rtl/sm83_alu_flags.sv
// sm83_alu_flags: SM83 flag register (Z,N,H,C) plus primary carry buffer.
//   Inputs : ALU status (alu_zero/half/carry), shift_out, daa_carry_out,
//            per-flag write enables and selects, f_load/dbus (POP AF),
//            pri_we/pri_clr (16-bit carry chain), cin_sel.
//   Outputs: f_out = {Z,N,H,C,0000}, flag taps for the control stage,
//            pri_carry, and the combinational ALU carry-in alu_cin.
// Flat port list keeps drop-in compatibility; sm83_alu_flags_if mirrors it.
module sm83_alu_flags
  import sm83_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic       alu_zero,
  input  logic       alu_half,
  input  logic       alu_carry,
  input  logic       shift_out,
  input  logic       daa_carry_out,
  input  logic       z_we,
  input  logic       n_we,
  input  logic       h_we,
  input  logic       c_we,
  input  logic       z_sel,
  input  logic       n_val,
  input  logic [1:0] h_sel,
  input  logic [2:0] c_sel,
  input  logic       f_load,
  input  logic [7:0] dbus,
  input  logic       pri_we,
  input  logic       pri_clr,
  input  logic [1:0] cin_sel,
  output logic [7:0] f_out,
  output logic       zero,
  output logic       carry,
  output logic       daa_carry,
  output logic       daa_neg,
  output logic       pri_carry,
  output logic       alu_cin
);

  logic z_q, n_q, h_q, c_q, pri_q;
  logic z_d, n_d, h_d, c_d, pri_d;

  // The low nibble of F is hard-wired to zero, so dbus[3:0] is never used.
  logic unused_dbus_lo;
  assign unused_dbus_lo = ^dbus[3:0];

  always_comb begin
    z_d   = z_q;
    n_d   = n_q;
    h_d   = h_q;
    c_d   = c_q;
    pri_d = pri_q;

    if (f_load) begin
      // POP AF overrides every individual flag write in the same cycle.
      {z_d, n_d, h_d, c_d} = dbus[7:4];
    end else begin
      if (z_we) z_d = z_sel ? 1'b0 : alu_zero;
      if (n_we) n_d = n_val;
      if (h_we) begin
        unique case (h_sel_t'(h_sel))
          H_ALU:   h_d = alu_half;
          H_ZERO:  h_d = 1'b0;
          H_ONE:   h_d = 1'b1;
          default: h_d = h_q;
        endcase
      end
      if (c_we) begin
        unique case (c_sel_t'(c_sel))
          C_ALU:   c_d = alu_carry;
          C_SHIFT: c_d = shift_out;
          C_DAA:   c_d = daa_carry_out;
          C_ZERO:  c_d = 1'b0;
          C_ONE:   c_d = 1'b1;
          C_CPL:   c_d = ~c_q;
          default: c_d = c_q;
        endcase
      end
    end

    // The carry buffer is independent of C so 16-bit ops chain bytes
    // without disturbing the architectural flags.
    if (pri_clr)     pri_d = 1'b0;
    else if (pri_we) pri_d = alu_carry;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      h_q   <= 1'b0;
      c_q   <= 1'b0;
      pri_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      n_q   <= n_d;
      h_q   <= h_d;
      c_q   <= c_d;
      pri_q <= pri_d;
    end
  end

  // Carry-in depends only on registered state, never on ALU inputs.
  always_comb begin
    alu_cin = 1'b0;
    unique case (cin_sel_t'(cin_sel))
      CIN_ZERO: alu_cin = 1'b0;
      CIN_ONE:  alu_cin = 1'b1;
      CIN_FLAG: alu_cin = c_q;
      CIN_PRI:  alu_cin = pri_q;
      default:  alu_cin = 1'b0;
    endcase
  end

  always_comb begin
    f_out         = '0;
    f_out[FLAG_Z] = z_q;
    f_out[FLAG_N] = n_q;
    f_out[FLAG_H] = h_q;
    f_out[FLAG_C] = c_q;
  end

  assign zero      = z_q;
  assign carry     = c_q;
  assign daa_carry = h_q;
  assign daa_neg   = n_q;
  assign pri_carry = pri_q;

  a_fload_excl: assert property (@(posedge clk) disable iff (!nreset)
    !(f_load && (z_we || n_we || h_we || c_we)))
    else $error("sm83_alu_flags: f_load with flag write enable");

  a_h_rsvd: assert property (@(posedge clk) disable iff (!nreset)
    !(!f_load && h_we && h_sel == H_RSVD))
    else $error("sm83_alu_flags: reserved h_sel");

  a_c_rsvd: assert property (@(posedge clk) disable iff (!nreset)
    !(!f_load && c_we && c_sel > C_CPL))
    else $error("sm83_alu_flags: reserved c_sel");

  a_ctl_known: assert property (@(posedge clk) disable iff (!nreset)
    !$isunknown({z_we, n_we, h_we, c_we, z_sel, n_val, h_sel, c_sel,
                 f_load, pri_we, pri_clr, cin_sel}))
    else $error("sm83_alu_flags: X on control input");

endmodule
